// File: rtl/sequence_generator.sv
// sequence_generator
//
// Serial pattern transmitter. On an accepted start it latches a W-bit
// pattern (either DEFAULT_PAT or the pattern input) and a repeat count.
// It then shifts the pattern out MSB first on o, repeating it
// back-to-back repeat_n+1 times. When the burst ends, done pulses for
// one cycle. Asserting abort during a burst ends it on the next edge
// without a done pulse.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       burst request, sampled only while idle
//   use_default 1: send DEFAULT_PAT, 0: send pattern (sampled with start)
//   pattern     W-bit pattern to send (sampled with start)
//   repeat_n    burst holds repeat_n+1 pattern copies (sampled with start)
//   abort       synchronous burst cancel, wins over start while idle
//   o           registered serial data, 0 whenever o_valid is low
//   o_valid     high while o carries a pattern bit
//   busy        high from start acceptance until done or abort
//   done        one-cycle pulse after the last bit of a burst
module sequence_generator #(
  parameter int               W           = 4,
  parameter int               CNT_W       = 4,
  parameter logic [W-1:0]     DEFAULT_PAT = 4'b1010
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_default,
  input  logic [W-1:0]     pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic             abort,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (W > 2) ? $clog2(W) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_n;
  logic [W-1:0]       shreg, shreg_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [CNT_W-1:0]   rep, rep_n;
  logic               o_n, o_valid_n, busy_n, done_n;
  logic [W-1:0]       sel_pat;

  assign sel_pat = use_default ? DEFAULT_PAT : pattern;

  // bit_idx holds the index of the bit currently on o. It reaches 0 on
  // the last bit of a copy. The edge that follows then either restarts
  // at the MSB of the next copy or closes the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      rep     <= '0;
      o       <= 1'b0;
      o_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_idx <= bit_idx_n;
      rep     <= rep_n;
      o       <= o_n;
      o_valid <= o_valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    rep_n     = rep;
    o_n       = o;
    o_valid_n = o_valid;
    busy_n    = busy;
    done_n    = 1'b0;

    case (state)
      IDLE: begin
        o_n       = 1'b0;
        o_valid_n = 1'b0;
        busy_n    = 1'b0;
        if (start && !abort) begin
          shreg_n   = sel_pat;
          rep_n     = repeat_n;
          o_n       = sel_pat[W-1];
          o_valid_n = 1'b1;
          busy_n    = 1'b1;
          bit_idx_n = IDX_W'(W-1);
          state_n   = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          o_n       = 1'b0;
          o_valid_n = 1'b0;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else if (bit_idx != '0) begin
          o_n       = shreg[bit_idx - IDX_W'(1)];
          bit_idx_n = bit_idx - IDX_W'(1);
        end else if (rep != '0) begin
          // The next copy starts on the very next cycle, with no gap.
          o_n       = shreg[W-1];
          bit_idx_n = IDX_W'(W-1);
          rep_n     = rep - CNT_W'(1);
        end else begin
          o_n       = 1'b0;
          o_valid_n = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        o_n       = 1'b0;
        o_valid_n = 1'b0;
        busy_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Testbench for sequence_generator. Outputs are sampled and inputs
// are driven on the falling edge of the clock.
module tb_sequence_generator;

  localparam int W     = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             use_default;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] repeat_n;
  logic             abort;
  logic             o;
  logic             o_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int fails  = 0;

  sequence_generator #(.W(W), .CNT_W(CNT_W), .DEFAULT_PAT(4'b1010)) dut (
    .clk(clk), .rst(rst), .start(start), .use_default(use_default),
    .pattern(pattern), .repeat_n(repeat_n), .abort(abort),
    .o(o), .o_valid(o_valid), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task test_reset();
    rst = 1'b0;
    #12;
    checks++; if (o !== 1'b0)       begin fails++; $display("[TB] FAIL reset_o: got %b expected 0", o); end
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_idle: got o_valid %b expected 0", o_valid); end
  endtask

  task test_default_single();
    logic [3:0] exp;
    exp = 4'b1010;
    @(negedge clk); use_default = 1'b1; repeat_n = 4'd0; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b0;
      checks++; if (o !== exp[3-i])  begin fails++; $display("[TB] FAIL single_o[%0d]: got %b expected %b", i, o, exp[3-i]); end
      checks++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, o_valid); end
      checks++; if (busy !== 1'b1)    begin fails++; $display("[TB] FAIL single_busy[%0d]: got %b expected 1", i, busy); end
      checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL single_early_done[%0d]: got %b expected 0", i, done); end
    end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_end_valid: got %b expected 0", o_valid); end
    checks++; if (o !== 1'b0)       begin fails++; $display("[TB] FAIL single_end_o: got %b expected 0", o); end
    checks++; if (done !== 1'b1)    begin fails++; $display("[TB] FAIL single_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL single_end_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL single_done_width: got %b expected 0", done); end
  endtask

  task test_repeat_loopback();
    logic [3:0] window;
    int det;
    int ones;
    window = 4'b0000; det = 0; ones = 0;
    @(negedge clk); use_default = 1'b1; repeat_n = 4'd2; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); start = 1'b0;
      checks++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL repeat_valid[%0d]: got %b expected 1", i, o_valid); end
      checks++; if (o !== ((i % 2) == 0)) begin fails++; $display("[TB] FAIL repeat_o[%0d]: got %b expected %b", i, o, ((i % 2) == 0)); end
      window = {window[2:0], o};
      if (i >= 3 && window == 4'b1010) det++;
    end
    @(negedge clk);
    checks++; if (done !== 1'b1)    begin fails++; $display("[TB] FAIL repeat_done: got %b expected 1", done); end
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL repeat_end_valid: got %b expected 0", o_valid); end
    checks++; if (det !== 5)        begin fails++; $display("[TB] FAIL repeat_detect_count: got %0d expected 5", det); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) ones++;
    end
    checks++; if (ones !== 0) begin fails++; $display("[TB] FAIL repeat_extra_done: got %0d expected 0", ones); end
  endtask

  task test_custom_isolation();
    logic [7:0] exp;
    int dones;
    exp = 8'b11011101; dones = 0;
    @(negedge clk); use_default = 1'b0; pattern = 4'b1101; repeat_n = 4'd1; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = (i == 2);
      if (i == 0) pattern = 4'b0000;
      checks++; if (o !== exp[7-i])   begin fails++; $display("[TB] FAIL custom_o[%0d]: got %b expected %b", i, o, exp[7-i]); end
      checks++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL custom_valid[%0d]: got %b expected 1", i, o_valid); end
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL custom_restart[%0d]: got o_valid %b expected 0", i, o_valid); end
    end
    checks++; if (dones !== 1) begin fails++; $display("[TB] FAIL custom_done_count: got %0d expected 1", dones); end
  endtask

  task test_abort();
    @(negedge clk); use_default = 1'b1; repeat_n = 4'd3; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); start = 1'b0;
      checks++; if (o !== ((i % 2) == 0)) begin fails++; $display("[TB] FAIL abort_o[%0d]: got %b expected %b", i, o, ((i % 2) == 0)); end
      if (i == 5) abort = 1'b1;
    end
    @(negedge clk); abort = 1'b0;
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_valid: got %b expected 0", o_valid); end
    checks++; if (o !== 1'b0)       begin fails++; $display("[TB] FAIL abort_o_low: got %b expected 0", o); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL abort_late_done: got %b expected 0", done); end
    abort = 1'b1; start = 1'b1; repeat_n = 4'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL abort_priority: got busy %b expected 0", busy); end
    abort = 1'b0;
    @(negedge clk); start = 1'b0;
    checks++; if (o_valid !== 1'b1 || o !== 1'b1) begin fails++; $display("[TB] FAIL abort_restart: got valid %b o %b expected 1 1", o_valid, o); end
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1)    begin fails++; $display("[TB] FAIL abort_restart_done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  task test_async_reset();
    int dones;
    dones = 0;
    @(negedge clk); use_default = 1'b1; repeat_n = 4'd1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start = 1'b0;
      checks++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL areset_pre_valid[%0d]: got %b expected 1", i, o_valid); end
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (o !== 1'b0)       begin fails++; $display("[TB] FAIL areset_o: got %b expected 0", o); end
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL areset_valid: got %b expected 0", o_valid); end
    checks++; if (busy !== 1'b0)    begin fails++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL areset_done: got %b expected 0", done); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL areset_idle[%0d]: got o_valid %b expected 0", i, o_valid); end
    end
    checks++; if (dones !== 0) begin fails++; $display("[TB] FAIL areset_no_done: got %0d expected 0", dones); end
  endtask

  task test_back_to_back();
    @(negedge clk); use_default = 1'b1; repeat_n = 4'hF; start = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (b == 1 && i == 0) start = 1'b0;
        checks++; if (o_valid !== 1'b1) begin fails++; $display("[TB] FAIL b2b_valid[%0d][%0d]: got %b expected 1", b, i, o_valid); end
        checks++; if (o !== ((i % 2) == 0)) begin fails++; $display("[TB] FAIL b2b_o[%0d][%0d]: got %b expected %b", b, i, o, ((i % 2) == 0)); end
      end
      @(negedge clk);
      checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_gap_valid[%0d]: got %b expected 0", b, o_valid); end
      checks++; if (done !== 1'b1)    begin fails++; $display("[TB] FAIL b2b_done[%0d]: got %b expected 1", b, done); end
      checks++; if (o !== 1'b0)       begin fails++; $display("[TB] FAIL b2b_gap_o[%0d]: got %b expected 0", b, o); end
    end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b_stop: got o_valid %b expected 0", o_valid); end
    checks++; if (done !== 1'b0)    begin fails++; $display("[TB] FAIL b2b_done_width: got %b expected 0", done); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; use_default = 1'b1; pattern = 4'b0000;
    repeat_n = '0; abort = 1'b0;
    test_reset();
    test_default_single();
    test_repeat_loopback();
    test_custom_isolation();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
